// File: rtl/serialrx.sv
// serialrx: UART receiver (8N1, LSB first) with a small receive FIFO behind a Wishbone slave.
// Define SERIALRX_FRAME_ERR_EN to check the stop bit and report framing errors.
module serialrx #(
    parameter int DIVIDE = 2,
    parameter int FRAME = 8,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data_w,
    output logic [31:0] wb_data_r,
    input  logic        wb_we,
    input  logic        wb_stb,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        wb_stall
);
    localparam int DW = $clog2(DIVIDE);
    localparam int IW = $clog2(FRAME);
    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] HALF = DW'(DIVIDE / 2 - 1);
    localparam logic [DW-1:0] LAST = DW'(DIVIDE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic             rx_m, rx_s, brk;
    logic [DW-1:0]    div_counter;
    logic [IW-1:0]    index;
    logic [FRAME-1:0] data;
    logic [FRAME-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic [31:0]      num_bytes, word0;
    logic             overrun, frame_err, stop_ok, stop_hit, push, push_ok;
    logic             rd0, pop, empty, full, unused;

`ifdef SERIALRX_FRAME_ERR_EN
    assign stop_ok = rx_s;
`else
    assign stop_ok = 1'b1;
`endif

    assign stop_hit = state == STOP && !brk && div_counter == LAST;
    assign push = stop_hit && stop_ok;
    assign empty = count == '0;
    assign full = count == (AW + 1)'(DEPTH);
    assign rd0 = wb_cyc && wb_stb && !wb_we && !wb_addr[2];
    assign pop = rd0 && !empty;
    // a same-cycle pop frees the slot the push needs
    assign push_ok = push && (!full || pop);
    assign wb_stall = 1'b0;
    assign unused = ^{wb_data_w, wb_addr[31:3], wb_addr[1:0]};

    always_comb begin
        word0 = '0;
        word0[FRAME-1:0] = empty ? '0 : mem[rd_ptr];
        word0[16] = !empty;
        word0[17] = overrun;
        word0[18] = frame_err;
    end

    always_ff @(posedge clk)
        if (rst) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {uart_rx, rx_m};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            div_counter <= '0;
            index <= '0;
            data <= '0;
            brk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_counter <= '0;
                    brk <= 1'b0;
                    if (!rx_s) state <= START;
                end
                START:
                    if (div_counter == HALF) begin
                        div_counter <= '0;
                        index <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else div_counter <= div_counter + 1'b1;
                DATA:
                    if (div_counter == LAST) begin
                        div_counter <= '0;
                        data[index] <= rx_s;
                        index <= index + 1'b1;
                        if (index == IW'(FRAME - 1)) state <= STOP;
                    end else div_counter <= div_counter + 1'b1;
                default:
                    // after a bad stop bit, hold here until the line returns high
                    if (brk) begin
                        if (rx_s) state <= IDLE;
                    end else if (div_counter == LAST) begin
                        div_counter <= '0;
                        if (stop_ok) state <= IDLE;
                        else brk <= 1'b1;
                    end else div_counter <= div_counter + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_ptr] <= data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            num_bytes <= '0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
            wb_ack <= 1'b0;
            wb_data_r <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                num_bytes <= num_bytes + 1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
            overrun <= (push && !push_ok) || (overrun && !rd0);
            frame_err <= (stop_hit && !stop_ok) || (frame_err && !rd0);
            wb_ack <= wb_cyc && wb_stb;
            if (wb_cyc && wb_stb && !wb_we) wb_data_r <= wb_addr[2] ? num_bytes : word0;
        end
    end
endmodule

// File: tb/tb_serialrx.sv
// tb_serialrx: directed frames and Wishbone reads against serialrx at DIVIDE=2.
module tb_serialrx;
    localparam int DIV = 2;

    logic        clk = 0, rst = 1, uart_rx = 1;
    logic        wb_we = 0, wb_stb = 0, wb_cyc = 0, wb_ack, wb_stall;
    logic [31:0] wb_addr = 0, wb_data_w = 0, wb_data_r;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    serialrx #(.DIVIDE(DIV), .FRAME(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .wb_addr(wb_addr), .wb_data_w(wb_data_w), .wb_data_r(wb_data_r),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_cyc(wb_cyc),
        .wb_ack(wb_ack), .wb_stall(wb_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // start bit, 8 data bits LSB first, stop bit; returns 20 negedges later with the line high
    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = 1;
    endtask

    task automatic rd(input string tag, input logic a, input logic [31:0] exp);
        wb_cyc = 1;
        wb_stb = 1;
        wb_we = 0;
        wb_addr = {29'b0, a, 2'b0};
        @(negedge clk);
        wb_cyc = 0;
        wb_stb = 0;
        check({tag, "_ack"}, {31'b0, wb_ack}, 32'd1);
        check(tag, wb_data_r, exp);
    endtask

    initial begin
        logic [9:0] f;
        int exp_nb;
        idle(3);
        check("rst_ack", {31'b0, wb_ack}, 0);
        check("rst_data", wb_data_r, 0);
        check("stall", {31'b0, wb_stall}, 0);
        rst = 0;
        idle(4);

        uart_rx = 0;
        @(negedge clk);
        uart_rx = 1;
        idle(10);
        rd("glitch_w0", 0, 32'h0);
        rd("glitch_nb", 1, 32'd0);

        send(8'hA5, 1);
        idle(4);
        rd("a5_w0", 0, 32'h000100A5);
        rd("a5_empty", 0, 32'h0);
        rd("a5_nb", 1, 32'd1);

        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_data_w = 32'hFFFF_FFFF; wb_addr = 0;
        @(negedge clk);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        check("wr_ack", {31'b0, wb_ack}, 1);
        idle(1);
        check("wr_ack_drop", {31'b0, wb_ack}, 0);

        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1);
            idle(4);
        end
        rd("ovr_1", 0, 32'h00030001);
        rd("ovr_2", 0, 32'h00010002);
        rd("ovr_3", 0, 32'h00010003);
        rd("ovr_4", 0, 32'h00010004);
        rd("ovr_e", 0, 32'h0);
        rd("ovr_nb", 1, 32'd5);

        for (int i = 8'h11; i <= 8'h14; i++) begin
            send(8'(i), 1);
            idle(4);
        end
        send(8'h15, 1);
        @(negedge clk);
        rd("race_head", 0, 32'h00010011);
        idle(4);
        rd("race_2", 0, 32'h00010012);
        rd("race_3", 0, 32'h00010013);
        rd("race_4", 0, 32'h00010014);
        rd("race_5", 0, 32'h00010015);
        rd("race_e", 0, 32'h0);
        rd("race_nb", 1, 32'd10);

        send(8'h3C, 0);
        idle(4);
`ifdef SERIALRX_FRAME_ERR_EN
        rd("ferr_w0", 0, 32'h00040000);
        rd("ferr_nb", 1, 32'd10);
        exp_nb = 11;
`else
        rd("nostop_w0", 0, 32'h0001003C);
        rd("nostop_nb", 1, 32'd11);
        exp_nb = 12;
`endif
        send(8'h3C, 1);
        idle(4);
        rd("good_w0", 0, 32'h0001003C);
        rd("good_nb", 1, 32'(exp_nb));

        f = {1'b1, 8'h7E, 1'b0};
        for (int i = 0; i < 5; i++) begin
            uart_rx = f[i];
            repeat (DIV) @(negedge clk);
        end
        rst = 1;
        wb_cyc = 1;
        wb_stb = 1;
        @(negedge clk);
        rst = 0;
        wb_cyc = 0;
        wb_stb = 0;
        uart_rx = 1;
        check("mid_rst_ack", {31'b0, wb_ack}, 0);
        check("mid_rst_data", wb_data_r, 0);
        idle(6);
        send(8'h7E, 1);
        idle(4);
        rd("post_rst_w0", 0, 32'h0001007E);
        rd("post_rst_e", 0, 32'h0);
        rd("post_rst_nb", 1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
